force_override_ctrl: RTL



---
 rtl/force_ctrl_pkg.sv | 27 ++
 rtl/force_override_ctrl_rr_arbiter.sv | 25 ++
 rtl/force_override_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/force_ctrl_pkg.sv
// Shared types and defaults for the force/override controller: state encoding,
// default bank geometry and a one-hot to index helper.
package force_ctrl_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NREQ   = 4;
    localparam int DEF_HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        FORCE,
        RELEASE
    } state_t;

    // Returns the position of the set bit; callers guarantee at most one bit is set.
    function automatic int onehot_to_index(input logic [31:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/force_override_ctrl_rr_arbiter.sv
// Combinational round-robin pick: scans req starting at ptr and returns the
// first requester found as a one-hot vector.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (en && !valid && req[(int'(ptr) + i) % NREQ]) begin
                grant[(int'(ptr) + i) % NREQ] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/force_override_ctrl.sv
// Arbitrated timed force/override in front of a D-register bank.
// Build option FORCE_MASK_EN adds a per-requester bit mask limiting which bits are forced.
module force_override_ctrl
    import force_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREQ   = DEF_NREQ,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       d,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  req_val,
    input  logic [NREQ*HOLD_W-1:0] req_hold,
`ifdef FORCE_MASK_EN
    input  logic [NREQ*WIDTH-1:0]  req_mask,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       q,
    output logic                   forcing
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   val_r, val_nxt;
    logic [WIDTH-1:0]   forced_q;
    logic [HOLD_W-1:0]  cnt, cnt_nxt;
    logic [HOLD_W-1:0]  hold_sel;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   win, win_nxt;
    logic [NREQ-1:0]    done_nxt;
    logic [NREQ-1:0]    arb_grant;
    logic               arb_valid;
    int                 arb_idx;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .en    (state == IDLE),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign arb_idx = onehot_to_index(32'(arb_grant));
    assign forcing = (state == FORCE);
    assign gnt     = forcing ? (NREQ'(1) << win) : '0;

`ifdef FORCE_MASK_EN
    logic [WIDTH-1:0] mask_r, mask_nxt;
    assign forced_q = (val_r & mask_r) | (d & ~mask_r);
`else
    assign forced_q = val_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            val_r <= '0;
            cnt   <= '0;
            ptr   <= '0;
            win   <= '0;
            done  <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            val_r <= val_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            done  <= done_nxt;
        end
    end

`ifdef FORCE_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
        end else begin
            mask_r <= mask_nxt;
        end
    end
`endif

    // q follows d except on FORCE edges where the owner still holds its request
    always_comb begin
        state_nxt = state;
        q_nxt     = d;
        val_nxt   = val_r;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        win_nxt   = win;
        done_nxt  = '0;
        hold_sel  = '0;
`ifdef FORCE_MASK_EN
        mask_nxt  = mask_r;
`endif
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = FORCE;
                    val_nxt   = req_val[arb_idx*WIDTH +: WIDTH];
`ifdef FORCE_MASK_EN
                    mask_nxt  = req_mask[arb_idx*WIDTH +: WIDTH];
`endif
                    hold_sel  = req_hold[arb_idx*HOLD_W +: HOLD_W];
                    cnt_nxt   = (hold_sel == '0) ? HOLD_W'(1) : hold_sel;
                    win_nxt   = PTR_W'(arb_idx);
                    ptr_nxt   = PTR_W'((arb_idx + 1) % NREQ);
                end
            end
            FORCE: begin
                if (!req[win]) begin
                    state_nxt = RELEASE;
                end else begin
                    q_nxt = forced_q;
                    if (cnt == HOLD_W'(1)) begin
                        state_nxt     = RELEASE;
                        done_nxt[win] = 1'b1;
                    end else begin
                        cnt_nxt = cnt - HOLD_W'(1);
                    end
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
